dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arb_pkg.sv | 21 ++
 rtl/dmem_arbiter.sv | 126 ++++++++++++
 tb/tb_dmem_arbiter.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared types and default sizes for the data-memory arbiter
package dmem_arb_pkg;

    localparam int DEF_ADDR_W     = 5;
    localparam int DEF_DATA_W     = 32;
    localparam int DEF_STARVE_MAX = 4;

    // Which port a read issued last cycle belongs to
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_P0   = 2'd1,
        OWN_P1   = 2'd2
    } owner_e;

    // Arbitration priority state
    typedef enum logic {
        P0_PRI = 1'b0,
        P1_PRI = 1'b1
    } arb_state_e;

endpackage

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port arbiter in front of a synchronous-read data memory
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic              clk_i,
    input  logic              reset_i,

    input  logic              p0_req_i,
    input  logic              p0_we_i,
    input  logic [ADDR_W-1:0] p0_addr_i,
    input  logic [DATA_W-1:0] p0_wdata_i,
    output logic              p0_stall_o,
    output logic              p0_rvalid_o,
    output logic [DATA_W-1:0] p0_rdata_o,

    input  logic              p1_valid_i,
    output logic              p1_ready_o,
    input  logic              p1_we_i,
    input  logic [ADDR_W-1:0] p1_addr_i,
    input  logic [DATA_W-1:0] p1_wdata_i,
    output logic              p1_rvalid_o,
    output logic [DATA_W-1:0] p1_rdata_o,

    output logic              mem_wr_valid_o,
    output logic [ADDR_W-1:0] mem_wr_addr_o,
    output logic [DATA_W-1:0] mem_wr_data_o,
    output logic              mem_rd_valid_o,
    output logic [ADDR_W-1:0] mem_rd_addr_o,
    input  logic [DATA_W-1:0] mem_rd_data_i
);

    localparam int CNT_W = (STARVE_MAX < 2) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STARVE_MAX - 1);

    arb_state_e       state, state_nx;
    logic [CNT_W-1:0] starve_cnt, starve_cnt_nx;
    owner_e           owner, owner_nx;
    logic             grant_p0, grant_p1;

    // Grant selection; reset suppresses every grant so nothing reaches memory
    always_comb begin
        grant_p0 = 1'b0;
        grant_p1 = 1'b0;
        if (reset_i) begin
            if (state == P1_PRI) begin
                grant_p1 = p1_valid_i;
                grant_p0 = p0_req_i & ~p1_valid_i;
            end else begin
                grant_p0 = p0_req_i;
                grant_p1 = p1_valid_i & ~p0_req_i;
            end
        end
    end

    // Next priority state and starvation count; port 1 gets one forced slot
    always_comb begin
        state_nx      = state;
        starve_cnt_nx = starve_cnt;
        if (state == P1_PRI) begin
            state_nx      = P0_PRI;
            starve_cnt_nx = '0;
        end else if (p1_valid_i && !grant_p1) begin
            if (starve_cnt == CNT_LAST) begin
                state_nx      = P1_PRI;
                starve_cnt_nx = '0;
            end else begin
                starve_cnt_nx = starve_cnt + CNT_W'(1);
            end
        end else begin
            starve_cnt_nx = '0;
        end
    end

    // Memory command mux and owner of the read being issued this cycle
    always_comb begin
        mem_wr_valid_o = 1'b0;
        mem_rd_valid_o = 1'b0;
        mem_wr_addr_o  = '0;
        mem_rd_addr_o  = '0;
        mem_wr_data_o  = '0;
        owner_nx       = OWN_NONE;
        if (grant_p0) begin
            mem_wr_valid_o = p0_we_i;
            mem_rd_valid_o = ~p0_we_i;
            mem_wr_addr_o  = p0_addr_i;
            mem_rd_addr_o  = p0_addr_i;
            mem_wr_data_o  = p0_wdata_i;
            owner_nx       = p0_we_i ? OWN_NONE : OWN_P0;
        end else if (grant_p1) begin
            mem_wr_valid_o = p1_we_i;
            mem_rd_valid_o = ~p1_we_i;
            mem_wr_addr_o  = p1_addr_i;
            mem_rd_addr_o  = p1_addr_i;
            mem_wr_data_o  = p1_wdata_i;
            owner_nx       = p1_we_i ? OWN_NONE : OWN_P1;
        end
    end

    // State, starvation counter and read-owner registers
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state      <= P0_PRI;
            starve_cnt <= '0;
            owner      <= OWN_NONE;
        end else begin
            state      <= state_nx;
            starve_cnt <= starve_cnt_nx;
            owner      <= owner_nx;
        end
    end

    // Port handshakes and read return routed by the registered owner
    always_comb begin
        p0_stall_o  = p0_req_i & ~grant_p0 & reset_i;
        p1_ready_o  = grant_p1;
        p0_rvalid_o = (owner == OWN_P0);
        p1_rvalid_o = (owner == OWN_P1);
        p0_rdata_o  = p0_rvalid_o ? mem_rd_data_i : '0;
        p1_rdata_o  = p1_rvalid_o ? mem_rd_data_i : '0;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed self-checking bench for dmem_arbiter
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset_i;
    logic        p0_req, p0_we, p0_stall, p0_rvalid;
    logic [4:0]  p0_addr;
    logic [31:0] p0_wdata, p0_rdata;
    logic        p1_valid, p1_ready, p1_we, p1_rvalid;
    logic [4:0]  p1_addr;
    logic [31:0] p1_wdata, p1_rdata;
    logic        mem_wr_valid, mem_rd_valid;
    logic [4:0]  mem_wr_addr, mem_rd_addr;
    logic [31:0] mem_wr_data, mem_rd_data;
    logic [31:0] mem [0:31];

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    dmem_arbiter dut (
        .clk_i(clk), .reset_i(reset_i),
        .p0_req_i(p0_req), .p0_we_i(p0_we), .p0_addr_i(p0_addr), .p0_wdata_i(p0_wdata),
        .p0_stall_o(p0_stall), .p0_rvalid_o(p0_rvalid), .p0_rdata_o(p0_rdata),
        .p1_valid_i(p1_valid), .p1_ready_o(p1_ready), .p1_we_i(p1_we), .p1_addr_i(p1_addr),
        .p1_wdata_i(p1_wdata), .p1_rvalid_o(p1_rvalid), .p1_rdata_o(p1_rdata),
        .mem_wr_valid_o(mem_wr_valid), .mem_wr_addr_o(mem_wr_addr), .mem_wr_data_o(mem_wr_data),
        .mem_rd_valid_o(mem_rd_valid), .mem_rd_addr_o(mem_rd_addr), .mem_rd_data_i(mem_rd_data)
    );

    // Synchronous-read data memory with one cycle of read latency
    always @(posedge clk) begin
        if (mem_wr_valid) mem[mem_wr_addr] <= mem_wr_data;
        if (mem_rd_valid) mem_rd_data <= mem[mem_rd_addr];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_i = 1'b0;
        p0_req = 1'b1; p0_we = 1'b0; p0_addr = 5'd3; p0_wdata = 32'h0;
        p1_valid = 1'b1; p1_we = 1'b1; p1_addr = 5'd4; p1_wdata = 32'h0;
        for (int c = 0; c < 3; c++) begin
            tick();
            compared++; if (p0_stall !== 1'b0) begin mismatched++; $display("FAIL reset_p0_stall: got %b expected 0", p0_stall); end
            compared++; if (p1_ready !== 1'b0) begin mismatched++; $display("FAIL reset_p1_ready: got %b expected 0", p1_ready); end
            compared++; if ({p0_rvalid, p1_rvalid} !== 2'b00) begin mismatched++; $display("FAIL reset_rvalid: got %b expected 00", {p0_rvalid, p1_rvalid}); end
            compared++; if ({p0_rdata, p1_rdata} !== 64'h0) begin mismatched++; $display("FAIL reset_rdata: got %h expected 0", {p0_rdata, p1_rdata}); end
            compared++; if ({mem_wr_valid, mem_rd_valid} !== 2'b00) begin mismatched++; $display("FAIL reset_mem_valid: got %b expected 00", {mem_wr_valid, mem_rd_valid}); end
        end
        p0_req = 1'b0; p1_valid = 1'b0;
        reset_i = 1'b1;
        tick();
    endtask

    task automatic test_preload();
        logic [4:0]  addrs [3] = '{5'd1, 5'd2, 5'd3};
        logic [31:0] datas [3] = '{32'h1111_1111, 32'h2222_2222, 32'hDEAD_BEEF};
        for (int i = 0; i < 3; i++) begin
            p0_req = 1'b1; p0_we = 1'b1; p0_addr = addrs[i]; p0_wdata = datas[i];
            #1;
            compared++; if ({mem_wr_valid, mem_rd_valid, p0_stall} !== 3'b100) begin mismatched++; $display("FAIL preload_wr: got %b expected 100", {mem_wr_valid, mem_rd_valid, p0_stall}); end
            tick();
        end
        p0_req = 1'b0;
        tick();
    endtask

    task automatic test_p0_read();
        p0_req = 1'b1; p0_we = 1'b0; p0_addr = 5'd3;
        #1;
        compared++; if ({mem_rd_valid, mem_wr_valid} !== 2'b10) begin mismatched++; $display("FAIL p0rd_mem_valid: got %b expected 10", {mem_rd_valid, mem_wr_valid}); end
        compared++; if (mem_rd_addr !== 5'd3) begin mismatched++; $display("FAIL p0rd_addr: got %0d expected 3", mem_rd_addr); end
        compared++; if (p0_stall !== 1'b0) begin mismatched++; $display("FAIL p0rd_stall: got %b expected 0", p0_stall); end
        tick();
        p0_req = 1'b0;
        #1;
        compared++; if (p0_rvalid !== 1'b1) begin mismatched++; $display("FAIL p0rd_rvalid: got %b expected 1", p0_rvalid); end
        compared++; if (p0_rdata !== 32'hDEAD_BEEF) begin mismatched++; $display("FAIL p0rd_rdata: got %h expected deadbeef", p0_rdata); end
        compared++; if (p1_rvalid !== 1'b0) begin mismatched++; $display("FAIL p0rd_p1_rvalid: got %b expected 0", p1_rvalid); end
        compared++; if (mem_rd_valid !== 1'b0) begin mismatched++; $display("FAIL p0rd_idle_mem: got %b expected 0", mem_rd_valid); end
        tick();
        compared++; if (p0_rvalid !== 1'b0) begin mismatched++; $display("FAIL p0rd_rvalid_drop: got %b expected 0", p0_rvalid); end
    endtask

    task automatic test_collide();
        p0_req = 1'b1; p0_we = 1'b1; p0_addr = 5'd7; p0_wdata = 32'hAAAA_0007;
        p1_valid = 1'b1; p1_we = 1'b1; p1_addr = 5'd7; p1_wdata = 32'hBBBB_0007;
        #1;
        compared++; if (p1_ready !== 1'b0) begin mismatched++; $display("FAIL col_p1_ready: got %b expected 0", p1_ready); end
        compared++; if (p0_stall !== 1'b0) begin mismatched++; $display("FAIL col_p0_stall: got %b expected 0", p0_stall); end
        compared++; if (mem_wr_data !== 32'hAAAA_0007) begin mismatched++; $display("FAIL col_wdata0: got %h expected aaaa0007", mem_wr_data); end
        tick();
        compared++; if (mem[7] !== 32'hAAAA_0007) begin mismatched++; $display("FAIL col_mem_a: got %h expected aaaa0007", mem[7]); end
        p0_req = 1'b0;
        #1;
        compared++; if (p1_ready !== 1'b1) begin mismatched++; $display("FAIL col_p1_ready2: got %b expected 1", p1_ready); end
        compared++; if (mem_wr_data !== 32'hBBBB_0007) begin mismatched++; $display("FAIL col_wdata1: got %h expected bbbb0007", mem_wr_data); end
        compared++; if ({p0_rvalid, p1_rvalid} !== 2'b00) begin mismatched++; $display("FAIL col_rvalid: got %b expected 00", {p0_rvalid, p1_rvalid}); end
        tick();
        p1_valid = 1'b0;
        compared++; if (mem[7] !== 32'hBBBB_0007) begin mismatched++; $display("FAIL col_mem_b: got %h expected bbbb0007", mem[7]); end
        compared++; if ({p0_rvalid, p1_rvalid} !== 2'b00) begin mismatched++; $display("FAIL col_wr_rvalid: got %b expected 00", {p0_rvalid, p1_rvalid}); end
        tick();
    endtask

    task automatic test_starve();
        logic exp;
        p0_req = 1'b1; p0_we = 1'b0; p0_addr = 5'd0;
        p1_valid = 1'b1; p1_we = 1'b1; p1_addr = 5'd5; p1_wdata = 32'h5555_5555;
        for (int k = 1; k <= 6; k++) begin
            if (k == 6) begin p1_addr = 5'd6; p1_wdata = 32'h6666_6666; end
            exp = (k == 5);
            #1;
            compared++; if (p1_ready !== exp) begin mismatched++; $display("FAIL starve_p1_ready c%0d: got %b expected %b", k, p1_ready, exp); end
            compared++; if (p0_stall !== exp) begin mismatched++; $display("FAIL starve_p0_stall c%0d: got %b expected %b", k, p0_stall, exp); end
            tick();
        end
        p0_req = 1'b0; p1_valid = 1'b0;
        compared++; if (mem[5] !== 32'h5555_5555) begin mismatched++; $display("FAIL starve_mem5: got %h expected 55555555", mem[5]); end
        tick();
    endtask

    task automatic test_alternate();
        p1_we = 1'b0; p1_addr = 5'd2;
        p0_we = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            p0_req = 1'b1;
            p0_addr = (k == 6) ? 5'd3 : 5'd1;
            p1_valid = (k <= 5);
            tick();
            if (k <= 4) begin
                compared++; if ({p0_rvalid, p1_rvalid} !== 2'b10 || p0_rdata !== 32'h1111_1111) begin mismatched++; $display("FAIL alt_p0_a1 c%0d: got %b/%h expected 10/11111111", k, {p0_rvalid, p1_rvalid}, p0_rdata); end
            end else if (k == 5) begin
                compared++; if ({p0_rvalid, p1_rvalid} !== 2'b01 || p1_rdata !== 32'h2222_2222) begin mismatched++; $display("FAIL alt_p1_a2: got %b/%h expected 01/22222222", {p0_rvalid, p1_rvalid}, p1_rdata); end
            end else begin
                compared++; if ({p0_rvalid, p1_rvalid} !== 2'b10 || p0_rdata !== 32'hDEAD_BEEF) begin mismatched++; $display("FAIL alt_p0_a3: got %b/%h expected 10/deadbeef", {p0_rvalid, p1_rvalid}, p0_rdata); end
            end
        end
        p0_req = 1'b0; p1_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_read();
        p0_req = 1'b1; p0_we = 1'b0; p0_addr = 5'd3;
        tick();
        p0_req = 1'b0;
        reset_i = 1'b0;
        #1;
        compared++; if (p0_rvalid !== 1'b0) begin mismatched++; $display("FAIL rmid_rvalid: got %b expected 0", p0_rvalid); end
        compared++; if (p0_rdata !== 32'h0) begin mismatched++; $display("FAIL rmid_rdata: got %h expected 0", p0_rdata); end
        tick();
        tick();
        reset_i = 1'b1;
        compared++; if (p0_rvalid !== 1'b0) begin mismatched++; $display("FAIL rmid_rvalid_after: got %b expected 0", p0_rvalid); end
        p0_req = 1'b1; p0_addr = 5'd1;
        #1;
        compared++; if ({mem_rd_valid, p0_stall} !== 2'b10) begin mismatched++; $display("FAIL rmid_first_grant: got %b expected 10", {mem_rd_valid, p0_stall}); end
        tick();
        p0_req = 1'b0;
        compared++; if (p0_rvalid !== 1'b1 || p0_rdata !== 32'h1111_1111) begin mismatched++; $display("FAIL rmid_first_read: got %b/%h expected 1/11111111", p0_rvalid, p0_rdata); end
        tick();
    endtask

    initial begin
        reset_i = 1'b0;
        p0_req = 1'b0; p0_we = 1'b0; p0_addr = '0; p0_wdata = '0;
        p1_valid = 1'b0; p1_we = 1'b0; p1_addr = '0; p1_wdata = '0;
        test_reset();
        test_preload();
        test_p0_read();
        test_collide();
        test_starve();
        test_alternate();
        test_reset_mid_read();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
